// File: rtl/cacheline_adaptor_pkg.sv
// rtl/cacheline_adaptor_pkg.sv - shared line/burst geometry and adaptor state encoding
package cacheline_adaptor_pkg;

    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int ADDR_W  = 32;
    localparam int BEATS   = LINE_W / BURST_W;
    localparam int CNT_W   = $clog2(BEATS);
    localparam int OFF_W   = $clog2(LINE_W / 8);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_BURST = 3'd1,
        RD_DONE  = 3'd2,
        WR_BURST = 3'd3,
        WR_DONE  = 3'd4
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - converts one cache-line transaction into a four-beat memory burst
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int LINE_W  = cacheline_adaptor_pkg::LINE_W,
    parameter int BURST_W = cacheline_adaptor_pkg::BURST_W,
    parameter int ADDR_W  = cacheline_adaptor_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LINE_W-1:0]   line_i,
    output logic [LINE_W-1:0]   line_o,
    input  logic [ADDR_W-1:0]   address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [BURST_W-1:0]  burst_i,
    output logic [BURST_W-1:0]  burst_o,
    output logic [ADDR_W-1:0]   address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    adaptor_state_t     state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [LINE_W-1:0]  buf_q, buf_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (read_i) begin
                    state_d = RD_BURST;
                end else if (write_i) begin
                    state_d = WR_BURST;
                end
            end
            RD_BURST: if (resp_i && count_q == LAST_BEAT) state_d = RD_DONE;
            WR_BURST: if (resp_i && count_q == LAST_BEAT) state_d = WR_DONE;
            RD_DONE:  state_d = IDLE;
            WR_DONE:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Counter wraps to zero naturally on the last beat since it is exactly CNT_W bits wide.
    always_comb begin
        count_d = count_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (read_i || write_i) begin
                    addr_d  = {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    count_d = '0;
                end
                if (!read_i && write_i) begin
                    buf_d = line_i;
                end
            end
            RD_BURST: begin
                if (resp_i) begin
                    buf_d[count_q*BURST_W +: BURST_W] = burst_i;
                    count_d = count_q + CNT_W'(1);
                end
            end
            WR_BURST: begin
                if (resp_i) begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        read_o    = (state_q == RD_BURST);
        write_o   = (state_q == WR_BURST);
        resp_o    = (state_q == RD_DONE) || (state_q == WR_DONE);
        address_o = addr_q;
        line_o    = buf_q;
        burst_o   = '0;
        if (state_q == WR_BURST) begin
            burst_o = buf_q[count_q*BURST_W +: BURST_W];
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - directed scoreboard bench for cacheline_adaptor
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int errors = 0;
    int checks = 0;

    logic [255:0] line_q[$];
    logic [63:0]  beat_q[$];
    logic [255:0] last_line;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_read_o"}, 256'(read_o), 256'(1'b0));
        chk({tag, "_write_o"}, 256'(write_o), 256'(1'b0));
        chk({tag, "_resp_o"}, 256'(resp_o), 256'(1'b0));
    endtask

    task automatic run_read(input logic [31:0] addr, input logic [255:0] line,
                            input logic [15:0] pat, input int plen, input logic also_write);
        int k;
        logic [255:0] exp_line;
        line_q.push_back(line);
        address_i = addr;
        read_i    = 1'b1;
        write_i   = also_write;
        tick();
        k = 0;
        for (int i = 0; i < plen; i++) begin
            chk("rd_read_o", 256'(read_o), 256'(1'b1));
            chk("rd_write_o", 256'(write_o), 256'(1'b0));
            chk("rd_resp_early", 256'(resp_o), 256'(1'b0));
            chk("rd_address_o", 256'(address_o), 256'(addr & 32'hffff_ffe0));
            resp_i  = pat[i];
            burst_i = pat[i] ? line[k*64 +: 64] : 64'hbad0_bad0_bad0_bad0;
            if (pat[i]) k++;
            tick();
        end
        resp_i  = 1'b0;
        burst_i = '0;
        chk("rd_resp_o", 256'(resp_o), 256'(1'b1));
        chk("rd_done_read_o", 256'(read_o), 256'(1'b0));
        exp_line = (line_q.size() > 0) ? line_q.pop_front() : 256'hx;
        chk("rd_line_o", line_o, exp_line);
        last_line = exp_line;
        read_i  = 1'b0;
        write_i = 1'b0;
        tick();
        chk_idle("rd_after");
        chk("rd_line_hold", line_o, exp_line);
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [255:0] line,
                             input logic [15:0] pat, input int plen);
        logic [63:0] exp_beat;
        for (int b = 0; b < 4; b++) beat_q.push_back(line[b*64 +: 64]);
        address_i = addr;
        line_i    = line;
        write_i   = 1'b1;
        tick();
        for (int i = 0; i < plen; i++) begin
            chk("wr_write_o", 256'(write_o), 256'(1'b1));
            chk("wr_read_o", 256'(read_o), 256'(1'b0));
            chk("wr_resp_early", 256'(resp_o), 256'(1'b0));
            chk("wr_address_o", 256'(address_o), 256'(addr & 32'hffff_ffe0));
            if (pat[i]) begin
                exp_beat = (beat_q.size() > 0) ? beat_q.pop_front() : 64'hx;
                chk("wr_burst_o", 256'(burst_o), 256'(exp_beat));
            end
            resp_i = pat[i];
            tick();
        end
        resp_i = 1'b0;
        chk("wr_resp_o", 256'(resp_o), 256'(1'b1));
        chk("wr_done_write_o", 256'(write_o), 256'(1'b0));
        write_i = 1'b0;
        tick();
        chk_idle("wr_after");
    endtask

    initial begin
        rst       = 1'b1;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        last_line = '0;
        tick();
        tick();
        chk_idle("reset");
        chk("reset_line_o", line_o, 256'h0);
        chk("reset_burst_o", 256'(burst_o), 256'h0);
        chk("reset_address_o", 256'(address_o), 256'h0);
        rst = 1'b0;
        tick();

        // back-to-back beats after one idle cycle: resp_o lands at cycle 6
        run_read(32'h1234_5678,
                 {64'h0000_0000_0000_0044, 64'h0000_0000_0000_0033,
                  64'h0000_0000_0000_0022, 64'h0000_0000_0000_0011},
                 16'b0001_1110, 5, 1'b0);
        chk("rd_aligned_addr", 256'(address_o), 256'(32'h1234_5660));

        run_write(32'h0000_a03f,
                  {64'hdddd_dddd_dddd_dddd, 64'hcccc_cccc_cccc_cccc,
                   64'hbbbb_bbbb_bbbb_bbbb, 64'haaaa_aaaa_aaaa_aaaa},
                  16'b0000_1111, 4);

        // gapped beats: 1,0,1,0,0,1,1
        run_read(32'hfedc_ba9f,
                 {64'h4444_0000_1111_0004, 64'h3333_0000_1111_0003,
                  64'h2222_0000_1111_0002, 64'h1111_0000_1111_0001},
                 16'b0110_0101, 7, 1'b0);

        resp_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("stray");
            chk("stray_line_o", line_o, last_line);
        end
        resp_i = 1'b0;
        tick();

        // read wins over a simultaneous write
        line_i = {4{64'h5a5a_5a5a_5a5a_5a5a}};
        run_read(32'h8000_0020,
                 {64'h0d0d_0d0d_0d0d_0d0d, 64'h0c0c_0c0c_0c0c_0c0c,
                  64'h0b0b_0b0b_0b0b_0b0b, 64'h0a0a_0a0a_0a0a_0a0a},
                 16'b0000_1111, 4, 1'b1);

        address_i = 32'h0bad_cafe;
        read_i    = 1'b1;
        tick();
        chk("midrst_read_o", 256'(read_o), 256'(1'b1));
        resp_i  = 1'b1;
        burst_i = 64'h7777_7777_7777_7777;
        tick();
        burst_i = 64'h8888_8888_8888_8888;
        tick();
        resp_i  = 1'b0;
        burst_i = '0;
        read_i  = 1'b0;
        rst     = 1'b1;
        tick();
        chk_idle("midrst");
        chk("midrst_line_o", line_o, 256'h0);
        chk("midrst_address_o", 256'(address_o), 256'h0);
        chk("midrst_burst_o", 256'(burst_o), 256'h0);
        rst = 1'b0;
        tick();
        chk_idle("midrst_post");

        run_read(32'h0000_1000,
                 {64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
                  64'h1357_9bdf_0246_8ace, 64'h0f1e_2d3c_4b5a_6978},
                 16'b0000_1111, 4, 1'b0);

        run_write(32'h0000_2000,
                  {64'h4, 64'h3, 64'h2, 64'h1},
                  16'b0010_1011, 6);

        chk("scoreboard_lines_drained", 256'(line_q.size()), 256'(0));
        chk("scoreboard_beats_drained", 256'(beat_q.size()), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
Bridges the cache's physical-memory port to the burst-oriented main memory. On the line side it is the responder to the cache controller's pmem_read/pmem_write/pmem_resp handshake. On the burst side it is the initiator toward the DRAM model, moving one 256-bit line as four 64-bit beats. It sits between the cache and physical memory in the mp3 top level.

Parameters:
LINE_W, 256, cache line width in bits
BURST_W, 64, memory beat width in bits
ADDR_W, 32, address width
(localparam BEATS = LINE_W/BURST_W = 4; CNT_W = $clog2(BEATS) = 2; OFF_W = $clog2(LINE_W/8) = 5)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
line_i  in  LINE_W  write line from cache
line_o  out  LINE_W  read line to cache
address_i  in  ADDR_W  line address from cache
read_i  in  1  line read request (cache pmem_read)
write_i  in  1  line write request (cache pmem_write)
resp_o  out  1  line transaction done (cache pmem_resp)
burst_i  in  BURST_W  read beat from memory
burst_o  out  BURST_W  write beat to memory
address_o  out  ADDR_W  line-aligned address to memory
read_o  out  1  burst read request
write_o  out  1  burst write request
resp_i  in  1  memory beat valid/accepted

Behaviour:
- Reset: state=IDLE, count=0, line buffer=0, address register=0. All outputs 0: line_o, burst_o, address_o, read_o, write_o, resp_o. A reset mid-burst aborts immediately; no resp_o is issued.
- States: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
- IDLE:
  - read_i=1: latch {address_i[ADDR_W-1:OFF_W], OFF_W'b0} into the address register; count=0; go to RD_BURST.
  - write_i=1: latch the same aligned address and line_i into the buffer; count=0; go to WR_BURST.
  - read_i and write_i both high: read wins.
  - resp_i in IDLE is ignored.
- RD_BURST:
  - read_o=1 throughout; address_o = address register.
  - Each cycle with resp_i=1 is one beat: buffer[count*BURST_W +: BURST_W] <= burst_i; count++.
  - Beats need not be consecutive.
  - On the beat with count==BEATS-1, go to RD_DONE.
- RD_DONE: resp_o=1 for exactly one cycle; line_o = assembled buffer; read_o=0; go to IDLE.
- WR_BURST:
  - write_o=1 throughout; address_o = address register; burst_o = buffer[count*BURST_W +: BURST_W].
  - On resp_i, count++.
  - After beat BEATS-1, go to WR_DONE.
- WR_DONE: resp_o=1 for one cycle; write_o=0; go to IDLE.
- line_o is driven from the line buffer. It is valid in the RD_DONE cycle and holds until the next transaction modifies the buffer.
- Latency:
  - Request sampled in IDLE at cycle N; read_o/write_o high at N+1.
  - resp_o is asserted the cycle after the 4th resp_i beat.
  - Minimum: request at 0, beats at 1–4, resp_o at 5.
- Requester contract:
  - Hold read_i/write_i and address_i/line_i stable until resp_o.
  - Deassert read_i/write_i in the cycle after resp_o; otherwise a new transaction starts.
  - read_i/write_i are ignored outside IDLE.
- The count wraps to 0 after the last beat. address_o always has its low OFF_W bits equal to 0.

Decomposition:
- Package cacheline_adaptor_pkg holds the state enum (adaptor_state_t) and the LINE_W/BURST_W/BEATS constants, shared with the cache datapath.
- No sub-module is needed. A single FSM plus a buffer-and-counter datapath is natural at this size; an optional beat_counter is not warranted.

Test Plan:
- Read, back-to-back beats: address_i=0x1234_5678, read_i=1; resp_i on cycles 2–5 with burst_i=0x0000_0000_0000_0011/…22/…33/…44 -> address_o=0x1234_5660; resp_o high only at cycle 6; line_o={…44,…33,…22,…11}.
- Write: line_i=256'h{D,C,B,A} (64-bit words, A lowest), write_i=1; resp_i held 4 cycles -> write_o high from cycle 1; burst_o sequence A,B,C,D; resp_o one cycle after D; write_o=0 afterward.
- Gapped read: resp_i pattern 1,0,1,0,0,1,1 -> exactly 4 beats captured in order; resp_o follows the last beat by one cycle; read_o stays high through the gaps.
- Simultaneous read_i=1, write_i=1 in IDLE -> read transaction (read_o=1, write_o=0).
- Reset after the 2nd read beat -> next cycle all outputs 0, state IDLE, no resp_o; a following read completes normally with a fresh count.
- Stray resp_i=1 in IDLE for 3 cycles -> no state change, no resp_o, line_o unchanged.
